// File: rtl/block_stream_gen.sv
// Block index/type evaluator with a runtime-writable platform table.
// Streams the current block's platform records over a valid/ready handshake.
module block_stream_gen #(
  parameter int BLOCK_NUM      = 7,
  parameter int PLAT_PER_BLOCK = 7,
  parameter int PHY_WIDTH      = 14,
  parameter int BLOCK_HEIGHT   = 480,
  parameter int LEN_WIDTH      = 4,
  parameter int IDX_WIDTH      = 6,
  parameter int TYPE_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic [PHY_WIDTH:0]                   abs_char_y,
  input  logic                                 y_valid,
  input  logic                                 cfg_we,
  input  logic [ADDR_WIDTH-1:0]                cfg_addr,
  input  logic [2*PHY_WIDTH+LEN_WIDTH-1:0]     cfg_wdata,
  output logic                                 busy,
  output logic [IDX_WIDTH-1:0]                 block_idx,
  output logic [TYPE_WIDTH-1:0]                block_type,
  output logic                                 block_switch,
  output logic                                 switch_up,
  output logic                                 plat_valid,
  input  logic                                 plat_ready,
  output logic [$clog2(PLAT_PER_BLOCK)-1:0]    plat_num,
  output logic [PHY_WIDTH-1:0]                 plat_x,
  output logic [PHY_WIDTH-1:0]                 plat_y,
  output logic [LEN_WIDTH-1:0]                 plat_len,
  output logic                                 plat_last
);
  localparam int TBL_N = BLOCK_NUM * PLAT_PER_BLOCK;
  localparam int NUM_W = $clog2(PLAT_PER_BLOCK);
  localparam int REC_W = 2*PHY_WIDTH + LEN_WIDTH;
  localparam int CNT_W = $clog2(PHY_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] TBL_N_A = ADDR_WIDTH'(TBL_N);

  typedef enum logic [2:0] {IDLE, DIV, MOD, UPD, STREAM} state_t;
  state_t state, state_nxt;

  logic [REC_W-1:0]      tbl [TBL_N];
  logic [PHY_WIDTH-1:0]  dvd, rem, rem_nxt;
  logic [PHY_WIDTH:0]    trial;
  logic                  take;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_WIDTH-1:0]  q_reg, m_reg;
  logic [REC_W-1:0]      rec, ld_data;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_en, div_last, mod_ge, is_last, hs;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign trial    = {rem, dvd[PHY_WIDTH-1]};
  assign take     = trial >= (PHY_WIDTH+1)'(BLOCK_HEIGHT);
  assign rem_nxt  = take ? PHY_WIDTH'(trial - (PHY_WIDTH+1)'(BLOCK_HEIGHT)) : PHY_WIDTH'(trial);
  assign div_last = cnt == CNT_W'(PHY_WIDTH - 1);
  assign mod_ge   = m_reg >= IDX_WIDTH'(BLOCK_NUM);
  assign is_last  = plat_num == NUM_W'(PLAT_PER_BLOCK - 1);
  assign hs       = (state == STREAM) && plat_ready;

  assign busy         = state != IDLE;
  assign plat_valid   = state == STREAM;
  assign plat_last    = (state == STREAM) && is_last;
  assign block_switch = (state == UPD) && (q_reg != block_idx);
  assign plat_x       = rec[REC_W-1 -: PHY_WIDTH];
  assign plat_y       = rec[LEN_WIDTH +: PHY_WIDTH];
  assign plat_len     = rec[LEN_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (y_valid) state_nxt = DIV;
      DIV:     if (div_last) state_nxt = MOD;
      MOD:     if (!mod_ge) state_nxt = UPD;
      UPD:     state_nxt = STREAM;
      STREAM:  if (plat_ready && is_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The next record is captured into rec when presented, so later table writes
  // cannot disturb a record held under backpressure; a same-cycle write is forwarded.
  always_comb begin
    ld_en   = 1'b0;
    ld_addr = '0;
    if (state == UPD) begin
      ld_en   = 1'b1;
      ld_addr = ADDR_WIDTH'(int'(m_reg) * PLAT_PER_BLOCK);
    end else if (hs && !is_last) begin
      ld_en   = 1'b1;
      ld_addr = ADDR_WIDTH'(int'(block_type) * PLAT_PER_BLOCK + int'(plat_num) + 1);
    end
    ld_data = (cfg_we && cfg_addr == ld_addr) ? cfg_wdata : tbl[ld_addr];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
    end else if (cfg_we && cfg_addr < TBL_N_A) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dvd        <= '0;
      rem        <= '0;
      cnt        <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      block_idx  <= '0;
      block_type <= '0;
      switch_up  <= 1'b0;
      plat_num   <= '0;
      rec        <= '0;
    end else begin
      case (state)
        IDLE: if (y_valid) begin
          dvd   <= abs_char_y[PHY_WIDTH] ? '0 : abs_char_y[PHY_WIDTH-1:0];
          rem   <= '0;
          cnt   <= '0;
          q_reg <= '0;
        end
        DIV: begin
          dvd   <= {dvd[PHY_WIDTH-2:0], 1'b0};
          rem   <= rem_nxt;
          cnt   <= cnt + CNT_W'(1);
          q_reg <= {q_reg[IDX_WIDTH-2:0], take};
          if (div_last) m_reg <= {q_reg[IDX_WIDTH-2:0], take};
        end
        MOD: if (mod_ge) m_reg <= m_reg - IDX_WIDTH'(BLOCK_NUM);
        UPD: begin
          block_idx  <= q_reg;
          block_type <= TYPE_WIDTH'(m_reg);
          plat_num   <= '0;
          if (q_reg != block_idx) switch_up <= q_reg > block_idx;
        end
        STREAM: if (hs && !is_last) plat_num <= plat_num + NUM_W'(1);
        default: ;
      endcase
      if (ld_en) rec <= ld_data;
    end
  end
endmodule

// File: tb/tb_block_stream_gen.sv
// Randomised/directed bench for block_stream_gen against an arithmetic reference model.
module tb_block_stream_gen;
  localparam int PW = 14, BN = 7, PP = 7, BH = 480, LW = 4, IW = 6, TW = 4, AW = 6, NW = 3;
  localparam int RW = 2*PW + LW;

  logic          sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [PW:0]   abs_char_y = '0;
  logic          y_valid = 1'b0, cfg_we = 1'b0, plat_ready = 1'b1;
  logic [AW-1:0] cfg_addr = '0;
  logic [RW-1:0] cfg_wdata = '0;
  logic          busy, block_switch, switch_up, plat_valid, plat_last;
  logic [IW-1:0] block_idx;
  logic [TW-1:0] block_type;
  logic [NW-1:0] plat_num;
  logic [PW-1:0] plat_x, plat_y;
  logic [LW-1:0] plat_len;

  block_stream_gen dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .abs_char_y(abs_char_y), .y_valid(y_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy),
    .block_idx(block_idx), .block_type(block_type), .block_switch(block_switch),
    .switch_up(switch_up), .plat_valid(plat_valid), .plat_ready(plat_ready),
    .plat_num(plat_num), .plat_x(plat_x), .plat_y(plat_y), .plat_len(plat_len),
    .plat_last(plat_last)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0, fails = 0;
  logic [RW-1:0] tbl_m [64];
  int prev_idx = 0;
  bit prev_up = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, want, want);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {31'd0, busy | block_switch | switch_up | plat_valid | plat_last |
              (|block_idx) | (|block_type) | (|plat_num) | (|plat_x) | (|plat_y) | (|plat_len)}, 0);
  endtask

  task automatic cfg_write(input int addr, input logic [RW-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr[AW-1:0]; cfg_wdata = data;
    @(negedge sys_clk);
    cfg_we = 1'b0;
    if (addr < BN*PP) tbl_m[addr] = data;
  endtask

  task automatic chk_rec(input string tag, input int k, input logic [RW-1:0] want);
    chk({tag, "_valid"}, plat_valid, 1);
    chk({tag, "_num"}, plat_num, k);
    chk({tag, "_fields"}, {plat_x, plat_y, plat_len}, want);
    chk({tag, "_last"}, plat_last, (k == PP-1));
  endtask

  // One full evaluation: y_valid pulse, latency/switch checks, then the whole record stream.
  task automatic evaluate(input int y, input int stall, input bit noise,
                          input int mid_addr, input logic [RW-1:0] mid_data);
    int ye, q, t, upd, c, pulses, pcyc;
    bit sw, exp_up;
    logic [RW-1:0] want, sdat;
    ye  = (y < 0) ? 0 : y;
    q   = (ye / BH) % (1 << IW);
    t   = q % BN;
    upd = PW + q / BN + 1 + 1;
    sw  = (q != prev_idx);
    exp_up = sw ? (q > prev_idx) : prev_up;
    abs_char_y = y[PW:0];
    y_valid = 1'b1;
    @(negedge sys_clk);
    y_valid = 1'b0;
    c = 1; pulses = 0; pcyc = -1;
    chk("busy_after_accept", busy, 1);
    while (!plat_valid && c < 200) begin
      if (block_switch) begin pulses++; pcyc = c; end
      if (noise && (c == 3 || c == 10)) begin
        y_valid = 1'b1; abs_char_y = PW'($urandom_range(0, 16383));
      end else y_valid = 1'b0;
      if (mid_addr >= 0 && c == 5) begin
        cfg_we = 1'b1; cfg_addr = mid_addr[AW-1:0]; cfg_wdata = mid_data;
      end else cfg_we = 1'b0;
      @(negedge sys_clk);
      if (mid_addr >= 0 && c == 5 && mid_addr < BN*PP) tbl_m[mid_addr] = mid_data;
      c++;
    end
    y_valid = 1'b0; cfg_we = 1'b0;
    chk("first_valid_cycle", c, upd + 1);
    if (!plat_valid) return;
    chk("switch_pulses", pulses, sw);
    if (sw) chk("switch_cycle", pcyc, upd);
    chk("block_idx", block_idx, q);
    chk("block_type", block_type, t);
    chk("switch_up", switch_up, exp_up);
    prev_idx = q; prev_up = exp_up;
    for (int k = 0; k < PP; k++) begin
      want = tbl_m[t*PP + k];
      chk_rec("rec", k, want);
      if (k == stall) begin
        plat_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          sdat = RW'($urandom);
          cfg_we = (s == 1); cfg_addr = AW'(t*PP + k); cfg_wdata = sdat;
          @(negedge sys_clk);
          if (s == 1) tbl_m[t*PP + k] = sdat;
          chk_rec("stall", k, want);
        end
        cfg_we = 1'b0;
      end
      plat_ready = 1'b1;
      @(negedge sys_clk);
    end
    chk("valid_after_last", plat_valid, 0);
    chk("busy_after_last", busy, 0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 64; i++) tbl_m[i] = '0;
    repeat (3) @(negedge sys_clk);
    chk_outputs_zero("reset_outputs");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk_outputs_zero("post_reset_outputs");

    for (int a = 0; a < BN*PP; a++) begin
      if (a < 7) cfg_write(a, {PW'(10*a), PW'(60*a), LW'(a + 1)});
      else       cfg_write(a, RW'($urandom));
    end

    evaluate(0, -1, 0, -1, '0);
    evaluate(500, -1, 0, -1, '0);
    evaluate(3400, -1, 0, -1, '0);
    evaluate(-20, -1, 0, -1, '0);
    evaluate(500, 3, 0, -1, '0);
    cfg_write(49, RW'($urandom));
    cfg_write(63, RW'($urandom));
    evaluate(600, -1, 1, 8, RW'($urandom));
    evaluate(479, 0, 0, -1, '0);
    evaluate(480, 6, 0, -1, '0);
    evaluate(16383, -1, 1, -1, '0);
    for (int i = 0; i < 12; i++)
      evaluate(int'($urandom_range(0, 18383)) - 2000, int'($urandom_range(0, 9)), 1'b0, -1, '0);

    // Abort mid-stream with the consumer stalled.
    plat_ready = 1'b0;
    abs_char_y = (PW+1)'(980);
    y_valid = 1'b1;
    @(negedge sys_clk);
    y_valid = 1'b0;
    c = 0;
    while (!plat_valid && c < 200) begin @(negedge sys_clk); c++; end
    chk("pre_reset_valid", plat_valid, 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk_outputs_zero("midstream_reset_outputs");
    sys_rst_n = 1'b1;
    plat_ready = 1'b1;
    for (int i = 0; i < 64; i++) tbl_m[i] = '0;
    prev_idx = 0; prev_up = 1'b0;
    @(negedge sys_clk);
    evaluate(0, 2, 0, -1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
- Parametrised successor to the fixed-table block/platform generator.
- Takes the character's absolute height and derives the block index and block type with multi-cycle arithmetic (no combinational divider).
- Keeps a runtime-writable platform table and streams the current block's platform records to the collision/render stage over a valid/ready handshake.
- Sits between the physics core (supplies abs_char_y) and the collision and VGA platform renderer.

Parameters:
- BLOCK_NUM, 7: number of distinct block layouts; block type = block index mod BLOCK_NUM.
- PLAT_PER_BLOCK, 7: platform records per block.
- PHY_WIDTH, 14: width of positions (x, y, unsigned).
- BLOCK_HEIGHT, 480: vertical span of one block; must be less than 2^PHY_WIDTH.
- LEN_WIDTH, 4: platform length field width.
- IDX_WIDTH, 6: block index width; must hold (2^PHY_WIDTH-1)/BLOCK_HEIGHT.
- TYPE_WIDTH, 4: block type width; must hold BLOCK_NUM-1.
- ADDR_WIDTH, 6: config address width; must hold BLOCK_NUM*PLAT_PER_BLOCK-1.

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- abs_char_y, in, PHY_WIDTH+1: signed absolute character height.
- y_valid, in, 1: request evaluation of abs_char_y.
- cfg_we, in, 1: table write strobe.
- cfg_addr, in, ADDR_WIDTH: table entry address, equal to type*PLAT_PER_BLOCK + platform.
- cfg_wdata, in, 2*PHY_WIDTH+LEN_WIDTH: {x, y, len}.
- busy, out, 1: evaluation or stream in progress.
- block_idx, out, IDX_WIDTH: current block index (quotient).
- block_type, out, TYPE_WIDTH: current block layout.
- block_switch, out, 1: one-cycle pulse when block_idx changes.
- switch_up, out, 1: direction of the last switch; 1 means the index increased.
- plat_valid, out, 1: record valid.
- plat_ready, in, 1: consumer accepts.
- plat_num, out, 3..: platform number within the block, width clog2(PLAT_PER_BLOCK).
- plat_x, out, PHY_WIDTH: platform x.
- plat_y, out, PHY_WIDTH: platform y relative to the block base.
- plat_len, out, LEN_WIDTH: platform length; 0 means the platform is disabled but the record is still streamed.
- plat_last, out, 1: final record of the block.

Behaviour:
- Reset values: every output is 0, and every table entry is 0. Reset mid-operation aborts the evaluation or stream immediately; no partial pulse.
- FSM states: IDLE, DIV, MOD, UPD, STREAM.
- IDLE: a y_valid high in IDLE is accepted. Negative abs_char_y is clamped to 0. Go to DIV next cycle with busy=1. y_valid while busy is ignored (not queued).
- DIV: restoring division by BLOCK_HEIGHT, one quotient bit per cycle, exactly PHY_WIDTH cycles. The quotient is truncated to IDX_WIDTH.
- MOD: subtract BLOCK_NUM from a copy of the quotient once per cycle while it is >= BLOCK_NUM. This takes floor(q/BLOCK_NUM)+1 cycles, the last cycle detecting "less than".
- UPD (1 cycle):
  - block_idx <= q and block_type <= remainder.
  - block_switch=1 for this cycle only if q differs from the previous block_idx; switch_up <= (q > previous) at the same time.
  - switch_up otherwise holds its value.
  - The first evaluation after reset compares against 0.
- STREAM:
  - Emits PLAT_PER_BLOCK records, plat_num 0..N-1, from table[block_type*PLAT_PER_BLOCK + plat_num].
  - plat_valid rises the cycle after UPD.
  - Record fields are stable while plat_valid=1 and plat_ready=0.
  - Advance on plat_valid & plat_ready; plat_last=1 on record N-1.
  - After the last handshake: plat_valid=0, busy=0, return to IDLE.
  - A stream occurs on every evaluation, whether or not the block switched.
- Table writes:
  - Accepted in any state when cfg_we=1 and cfg_addr < BLOCK_NUM*PLAT_PER_BLOCK; out-of-range writes are dropped.
  - A write in cycle N is visible to records presented from cycle N+1.
  - A record already presented and held under backpressure does not change.
- Arithmetic: all y values are unsigned after clamping. plat_y is block-relative; adding the block base is the consumer's job.

Test Plan:
- Reset, load table entries 0..6 with x=10*k, y=60*k, len=k+1; y_valid with y=0 → block_idx=0, type=0, no block_switch; 7 records k=0..6 with plat_last on k=6; busy drops after the last handshake.
- y=500 after y=0 → block_idx=1, type=1, block_switch pulse exactly 1 cycle, switch_up=1; records come from entries 7..13; UPD occurs PHY_WIDTH+1+1 cycles after acceptance.
- y=3400 → block_idx=7, type=0 (MOD takes 2 cycles), switch_up=1; then y=-20 → clamped to 0, block_idx=0, switch_up=0, block_switch pulse.
- Backpressure: plat_ready low for 5 cycles on record 3 → plat_valid held, fields stable, no record skipped or duplicated; a cfg write to that record's entry during the stall leaves the held record unchanged.
- y_valid pulses while busy=1 are ignored; a cfg write to address 49 (out of range with defaults) has no effect; a write to address 8 before UPD appears in record 1 of type 1.
- Assert sys_rst_n low mid-STREAM → all outputs 0 next edge, table cleared; next y=0 evaluation produces no switch pulse.
